mips_bus_arbiter: RTL and testbench
===================================

// Module: mips_bus_arbiter
// PURPOSE
//  Shares the single Avalon-MM master port of mips_cpu_bus between two requesters:
//  port 0 = instruction fetch, port 1 = data load/store.
//  Grants one requester at a time and registers all bus outputs.
//  Holds them stable while waitrequest is high, then returns readdata with a one-cycle ack.
//  Sits between the CPU control FSM and the top-level address/read/write/byteenable pins.
// PARAMETERS
//  ADDR_W   32         address width
//  DATA_W   32         data width
//  BE_W     DATA_W/8   byteenable width
// PORTS
//  clk          in   1       system clock
//  reset        in   1       asynchronous, active-high reset
//  req[1:0]     in   2       per-port request; held high until that port's ack
//  we[1:0]      in   2       per-port: 1 = write, 0 = read (valid while req)
//  addr0/addr1  in   ADDR_W  per-port address (valid while req)
//  wdata1       in   DATA_W  data-port write data (port 0 is read-only; we[0] ignored)
//  be0/be1      in   BE_W    per-port byteenable
//  ack[1:0]     out  2       one-cycle completion pulse to the granted port
//  rdata        out  DATA_W  registered read data, valid in ack cycle and held until next ack
//  grant        out  1       index of current/last granted port
//  busy         out  1       high in ISSUE and DONE states
//  address      out  ADDR_W  Avalon address
//  read, write  out  1       Avalon strobes (never both high)
//  writedata    out  DATA_W  Avalon write data
//  byteenable   out  BE_W    Avalon byteenable
//  waitrequest  in   1       Avalon stall
//  readdata     in   DATA_W  Avalon read data
// BEHAVIOUR
//  Reset (async, any state):
//   - state = IDLE
//   - address, writedata, rdata = 0; byteenable = 0; read = write = 0
//   - ack = 0; grant = 0; busy = 0
//   - In-flight transaction abandoned; no ack issued.
//  FSM:
//   - IDLE:  if |req at posedge -> select winner; register address/byteenable/writedata
//            and read = ~we, write = we (port 0: read only); grant <= winner; -> ISSUE.
//   - ISSUE: bus outputs frozen. If waitrequest == 0 at posedge:
//            rdata <= readdata (reads only; writes leave rdata unchanged);
//            ack[grant] <= 1; read = write = 0; -> DONE.
//            Otherwise stay in ISSUE (unbounded wait).
//   - DONE:  ack high this cycle only; -> IDLE unconditionally. req is not sampled
//            in DONE, so the acked port has one cycle to drop req.
//  Latency: minimum 3 cycles from req sampled to return to IDLE (ISSUE + DONE + IDLE);
//           each waitrequest-high cycle adds one.
//  Arbitration (simultaneous req) without macro: fixed priority, port 1 (data) wins.
//  A losing request stays pending and is granted on the next IDLE.
//  req dropping mid-transaction is ignored; the transaction completes and acks.
// CONFIGURATION
//  ARB_ROUND_ROBIN_EN defined:
//   - On simultaneous req, the port NOT granted last wins (uses registered grant).
//   - Single req is always granted immediately.
//  ARB_ROUND_ROBIN_EN undefined: fixed priority as above; no history state.
// STRUCTURE
//  Package mips_bus_pkg:
//   - arb_state_t enum {IDLE, ISSUE, DONE}
//   - localparams PORT_IFETCH = 0, PORT_DATA = 1
//  Sub-module arb_grant_select: combinational winner from req[1:0] and last grant;
//  contains the ARB_ROUND_ROBIN_EN ifdef.
// TESTING
//  1. Reset then req=01, addr0=0xBFC00000, waitrequest=0, readdata=0x3C020001
//     -> read=1 one cycle later; ack=01 next; rdata=0x3C020001.
//  2. req=10, we=10, addr1=0x100, wdata1=0xDEADBEEF, be1=0xF, waitrequest high 3 cycles
//     -> write held with all bus outputs stable 4 cycles; ack=10 after waitrequest low;
//        rdata unchanged.
//  3. req=11 held continuously, waitrequest=0, fixed priority
//     -> grants 1,0,1? no: always port 1 until it drops req; with ARB_ROUND_ROBIN_EN
//        -> grants alternate 1,0,1,0.
//  4. Assert reset while in ISSUE with waitrequest high
//     -> next cycle read=write=0, ack=0, busy=0, state IDLE; no ack later.
//  5. Port 0 request with we[0]=1
//     -> issues read (write never asserted); read and write never both 1
//        (assertion over all tests).
//  6. req pulse dropped in ISSUE -> transaction still completes and ack pulses once.

Source files
------------

// File: rtl/mips_bus_pkg.sv
// Shared types and constants for the mips_cpu_bus Avalon-MM arbiter.
package mips_bus_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DONE  = 2'd2
   } arb_state_t;

   localparam logic PORT_IFETCH = 1'b0;
   localparam logic PORT_DATA   = 1'b1;

endpackage

// File: rtl/mips_bus_arbiter_if.sv
// Requester-side and Avalon-side signals of the bus arbiter.
// master: the arbiter's view; slave: the view of the CPU/memory environment.
interface mips_bus_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int BE_W   = DATA_W / 8
);
   // Requester side
   logic [1:0]        req;
   logic [1:0]        we;
   logic [ADDR_W-1:0] addr0;
   logic [ADDR_W-1:0] addr1;
   logic [DATA_W-1:0] wdata1;
   logic [BE_W-1:0]   be0;
   logic [BE_W-1:0]   be1;
   logic [1:0]        ack;
   logic [DATA_W-1:0] rdata;
   logic              grant;
   logic              busy;
   // Avalon-MM side
   logic [ADDR_W-1:0] address;
   logic              read;
   logic              write;
   logic [DATA_W-1:0] writedata;
   logic [BE_W-1:0]   byteenable;
   logic              waitrequest;
   logic [DATA_W-1:0] readdata;

   modport master (
      input  req, we, addr0, addr1, wdata1, be0, be1,
      output ack, rdata, grant, busy,
      output address, read, write, writedata, byteenable,
      input  waitrequest, readdata
   );

   modport slave (
      output req, we, addr0, addr1, wdata1, be0, be1,
      input  ack, rdata, grant, busy,
      input  address, read, write, writedata, byteenable,
      output waitrequest, readdata
   );
endinterface

// File: rtl/arb_grant_select.sv
// Combinational winner selection for the two requesters.
// ARB_ROUND_ROBIN_EN: on a tie, the port not granted last wins; otherwise port 1 has priority.
module arb_grant_select
   import mips_bus_pkg::*;
(
   input  logic [1:0] req,
`ifdef ARB_ROUND_ROBIN_EN
   input  logic       last_grant,
`endif
   output logic       winner
);

   // Pick the winning port index; a single request always wins
   always_comb begin
      winner = PORT_IFETCH;
      if (req == 2'b11) begin
`ifdef ARB_ROUND_ROBIN_EN
         winner = ~last_grant;
`else
         winner = PORT_DATA;
`endif
      end else if (req[1]) begin
         winner = PORT_DATA;
      end
   end

endmodule

// File: rtl/mips_bus_arbiter.sv
// Two-port (ifetch / data) arbiter in front of the mips_cpu_bus Avalon-MM master.
// All bus outputs are registered and held while waitrequest is high.
// Optional macro ARB_ROUND_ROBIN_EN selects round-robin tie-breaking.
module mips_bus_arbiter
   import mips_bus_pkg::*;
(
   input logic               clk,
   input logic               reset,
   mips_bus_arbiter_if.master bus
);

   arb_state_t state_q, state_d;
   logic       winner;

   arb_grant_select u_grant_select (
      .req        (bus.req),
`ifdef ARB_ROUND_ROBIN_EN
      .last_grant (bus.grant),
`endif
      .winner     (winner)
   );

   assign bus.busy = (state_q != IDLE);

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (|bus.req) state_d = ISSUE;
         ISSUE:   if (!bus.waitrequest) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Registered bus outputs, grant, ack pulse and captured read data
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bus.address    <= '0;
         bus.writedata  <= '0;
         bus.byteenable <= '0;
         bus.read       <= 1'b0;
         bus.write      <= 1'b0;
         bus.rdata      <= '0;
         bus.ack        <= '0;
         bus.grant      <= PORT_IFETCH;
      end else begin
         bus.ack <= '0;
         case (state_q)
            IDLE: begin
               if (|bus.req) begin
                  bus.grant <= winner;
                  if (winner == PORT_DATA) begin
                     bus.address    <= bus.addr1;
                     bus.byteenable <= bus.be1;
                     bus.writedata  <= bus.wdata1;
                     bus.write      <= bus.we[1];
                     bus.read       <= ~bus.we[1];
                  end else begin
                     // Instruction fetch is read-only: we[0] is ignored
                     bus.address    <= bus.addr0;
                     bus.byteenable <= bus.be0;
                     bus.writedata  <= '0;
                     bus.write      <= 1'b0;
                     bus.read       <= 1'b1;
                  end
               end
            end
            ISSUE: begin
               if (!bus.waitrequest) begin
                  if (bus.read) bus.rdata <= bus.readdata;
                  bus.ack[bus.grant] <= 1'b1;
                  bus.read           <= 1'b0;
                  bus.write          <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Directed self-checking bench for mips_bus_arbiter.
// Follows ARB_ROUND_ROBIN_EN for the tie-break expectations.
module tb_mips_bus_arbiter;

   logic clk;
   logic reset;
   int   n_cmp;
   int   n_err;

   mips_bus_arbiter_if bus ();

   mips_bus_arbiter dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.master)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // read and write must never be asserted together
   always @(negedge clk) begin
      if (bus.read === 1'b1 && bus.write === 1'b1) begin
         n_err++;
         $display("FAIL rw_exclusive: read=%b write=%b required not both 1", bus.read, bus.write);
      end
   end

   task automatic wait_ack(input int budget, output logic [1:0] a);
      a = 2'b00;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (bus.ack !== 2'b00) begin
            a = bus.ack;
            return;
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      n_cmp++;
      if ({bus.read, bus.write, bus.ack, bus.grant, bus.busy} !== 6'b0) begin
         n_err++;
         $display("FAIL reset_ctrl: got %b want 000000",
                  {bus.read, bus.write, bus.ack, bus.grant, bus.busy});
      end
      n_cmp++;
      if ({bus.address, bus.writedata, bus.rdata, bus.byteenable} !== 100'b0) begin
         n_err++;
         $display("FAIL reset_data: addr=%h wdata=%h rdata=%h be=%h want all 0",
                  bus.address, bus.writedata, bus.rdata, bus.byteenable);
      end
      reset = 1'b0;
   endtask

   task automatic test_read();
      bus.req = 2'b01; bus.we = 2'b00; bus.addr0 = 32'hBFC0_0000; bus.be0 = 4'hF;
      bus.waitrequest = 1'b0; bus.readdata = 32'h3C02_0001;
      @(negedge clk);
      n_cmp++;
      if ({bus.read, bus.write, bus.busy, bus.grant} !== 4'b1010 || bus.address !== 32'hBFC0_0000) begin
         n_err++;
         $display("FAIL read_issue: rd/wr/busy/grant=%b addr=%h want 1010 bfc00000",
                  {bus.read, bus.write, bus.busy, bus.grant}, bus.address);
      end
      @(negedge clk);
      n_cmp++;
      if (bus.ack !== 2'b01 || bus.read !== 1'b0) begin
         n_err++;
         $display("FAIL read_ack: ack=%b read=%b want 01 0", bus.ack, bus.read);
      end
      n_cmp++;
      if (bus.rdata !== 32'h3C02_0001) begin
         n_err++;
         $display("FAIL read_rdata: got %h want 3c020001", bus.rdata);
      end
      bus.req = 2'b00;
      @(negedge clk);
      n_cmp++;
      if (bus.ack !== 2'b00 || bus.busy !== 1'b0) begin
         n_err++;
         $display("FAIL read_idle: ack=%b busy=%b want 00 0", bus.ack, bus.busy);
      end
   endtask

   task automatic test_write_stall();
      logic [1:0] a;
      bus.req = 2'b10; bus.we = 2'b10; bus.addr1 = 32'h100; bus.wdata1 = 32'hDEAD_BEEF;
      bus.be1 = 4'hF; bus.waitrequest = 1'b1; bus.readdata = 32'h1234_5678;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         n_cmp++;
         if ({bus.write, bus.read, bus.address, bus.writedata, bus.byteenable, bus.ack}
             !== {1'b1, 1'b0, 32'h100, 32'hDEAD_BEEF, 4'hF, 2'b00}) begin
            n_err++;
            $display("FAIL write_hold[%0d]: wr=%b rd=%b addr=%h wd=%h be=%h ack=%b want 1 0 100 deadbeef f 00",
                     i, bus.write, bus.read, bus.address, bus.writedata, bus.byteenable, bus.ack);
         end
      end
      bus.waitrequest = 1'b0;
      wait_ack(3, a);
      n_cmp++;
      if (a !== 2'b10 || bus.write !== 1'b0) begin
         n_err++;
         $display("FAIL write_ack: ack=%b write=%b want 10 0", a, bus.write);
      end
      n_cmp++;
      if (bus.rdata !== 32'h3C02_0001) begin
         n_err++;
         $display("FAIL write_rdata_kept: got %h want 3c020001", bus.rdata);
      end
      bus.req = 2'b00; bus.we = 2'b00;
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      logic [1:0] a;
      logic [1:0] exp;
      test_reset();
      bus.req = 2'b11; bus.we = 2'b00; bus.addr0 = 32'h40; bus.addr1 = 32'h80;
      bus.waitrequest = 1'b0; bus.readdata = 32'h5555_AAAA;
      for (int i = 0; i < 4; i++) begin
`ifdef ARB_ROUND_ROBIN_EN
         exp = (i % 2 == 0) ? 2'b10 : 2'b01;
`else
         exp = 2'b10;
`endif
         wait_ack(6, a);
         if (i == 3) bus.req = 2'b00;
         n_cmp++;
         if (a !== exp) begin
            n_err++;
            $display("FAIL b2b_ack[%0d]: got %b want %b", i, a, exp);
         end
      end
      @(negedge clk);
   endtask

   task automatic test_reset_in_issue();
      logic [1:0] acc;
      bus.req = 2'b01; bus.we = 2'b00; bus.addr0 = 32'hBFC0_0010; bus.waitrequest = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (bus.read !== 1'b1 || bus.busy !== 1'b1) begin
         n_err++;
         $display("FAIL rst_pre_issue: read=%b busy=%b want 1 1", bus.read, bus.busy);
      end
      reset = 1'b1;
      bus.req = 2'b00;
      @(negedge clk);
      n_cmp++;
      if ({bus.read, bus.write, bus.ack, bus.busy} !== 5'b0 || bus.address !== 32'h0
          || bus.rdata !== 32'h0) begin
         n_err++;
         $display("FAIL rst_in_issue: rd/wr/ack/busy=%b addr=%h rdata=%h want 00000 0 0",
                  {bus.read, bus.write, bus.ack, bus.busy}, bus.address, bus.rdata);
      end
      reset = 1'b0;
      bus.waitrequest = 1'b0;
      acc = 2'b00;
      repeat (5) begin
         @(negedge clk);
         acc = acc | bus.ack;
      end
      n_cmp++;
      if (acc !== 2'b00) begin
         n_err++;
         $display("FAIL rst_no_late_ack: got %b want 00", acc);
      end
   endtask

   task automatic test_port0_write_ignored();
      bus.req = 2'b01; bus.we = 2'b01; bus.addr0 = 32'h0000_0400; bus.be0 = 4'h3;
      bus.waitrequest = 1'b0; bus.readdata = 32'h0BAD_F00D;
      @(negedge clk);
      n_cmp++;
      if ({bus.read, bus.write} !== 2'b10 || bus.byteenable !== 4'h3) begin
         n_err++;
         $display("FAIL p0_we_read: rd/wr=%b be=%h want 10 3", {bus.read, bus.write}, bus.byteenable);
      end
      @(negedge clk);
      n_cmp++;
      if (bus.ack !== 2'b01 || bus.rdata !== 32'h0BAD_F00D) begin
         n_err++;
         $display("FAIL p0_we_ack: ack=%b rdata=%h want 01 0badf00d", bus.ack, bus.rdata);
      end
      bus.req = 2'b00; bus.we = 2'b00;
      @(negedge clk);
   endtask

   task automatic test_req_drop();
      int         n_ack;
      logic [1:0] last;
      bus.req = 2'b10; bus.we = 2'b00; bus.addr1 = 32'h200;
      bus.waitrequest = 1'b1; bus.readdata = 32'hCAFE_F00D;
      @(negedge clk);
      bus.req = 2'b00;
      @(negedge clk);
      bus.waitrequest = 1'b0;
      n_ack = 0;
      last  = 2'b00;
      repeat (6) begin
         @(negedge clk);
         if (bus.ack !== 2'b00) begin
            n_ack++;
            last = bus.ack;
         end
      end
      n_cmp++;
      if (n_ack != 1 || last !== 2'b10) begin
         n_err++;
         $display("FAIL req_drop_ack: count=%0d ack=%b want 1 10", n_ack, last);
      end
      n_cmp++;
      if (bus.rdata !== 32'hCAFE_F00D) begin
         n_err++;
         $display("FAIL req_drop_rdata: got %h want cafef00d", bus.rdata);
      end
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      reset = 1'b1;
      bus.req = 2'b00; bus.we = 2'b00; bus.addr0 = '0; bus.addr1 = '0; bus.wdata1 = '0;
      bus.be0 = '0; bus.be1 = '0; bus.waitrequest = 1'b0; bus.readdata = '0;
      test_reset();
      test_read();
      test_write_stall();
      test_back_to_back();
      test_reset_in_issue();
      test_port0_write_ignored();
      test_req_drop();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
